// File: rtl/pipelined_parallel_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipelined_parallel_adder                                         |
// | Brief   : WIDTH-bit adder/subtractor, carry chain cut into CHUNK-bit        |
// |           registered slices, valid/ready handshake at both ends.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_parallel_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Stage k registers: operands (upper slices still pending), partial sum, carry, valid
    logic [WIDTH-1:0]  r_a_q [STAGES];
    logic [WIDTH-1:0]  r_b_q [STAGES];
    logic [WIDTH-1:0]  r_s_q [STAGES];
    logic [STAGES-1:0] r_c_q;
    logic [STAGES-1:0] r_v_q;
    logic              r_ovf_q;

    logic [WIDTH-1:0]  w_a_d  [STAGES];
    logic [WIDTH-1:0]  w_b_d  [STAGES];
    logic [WIDTH-1:0]  w_s_in [STAGES];
    logic [WIDTH-1:0]  w_s_d  [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_c_d;
    logic [STAGES-1:0] w_v_d;
    logic [STAGES-1:0] w_load;
    logic              w_ovf_d;

    // A stage may load if it is empty or its occupant moves on this cycle.
    always_comb begin : load_chain
        logic l_take;
        l_take               = !r_v_q[STAGES-1] || out_ready;
        w_load               = '0;
        w_load[STAGES-1]     = l_take;
        for (int k = STAGES - 2; k >= 0; k--) begin
            l_take    = !r_v_q[k] || l_take;
            w_load[k] = l_take;
        end
    end

    always_comb begin : datapath
        logic [CHUNK:0] l_slice;
        l_slice   = '0;
        w_a_d[0]  = A;
        w_b_d[0]  = sub ? ~B : B;
        w_s_in[0] = '0;
        w_c_in[0] = sub ? ~cin : cin;
        w_v_d[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_d[k]  = r_a_q[k-1];
            w_b_d[k]  = r_b_q[k-1];
            w_s_in[k] = r_s_q[k-1];
            w_c_in[k] = r_c_q[k-1];
            w_v_d[k]  = r_v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            l_slice = {1'b0, w_a_d[k][k*CHUNK +: CHUNK]}
                    + {1'b0, w_b_d[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, w_c_in[k]};
            w_s_d[k]                   = w_s_in[k];
            w_s_d[k][k*CHUNK +: CHUNK] = l_slice[CHUNK-1:0];
            w_c_d[k]                   = l_slice[CHUNK];
        end
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        w_ovf_d = w_a_d[STAGES-1][WIDTH-1] ^ w_b_d[STAGES-1][WIDTH-1]
                ^ w_s_d[STAGES-1][WIDTH-1] ^ w_c_d[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_q   <= '0;
            r_c_q   <= '0;
            r_ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a_q[k] <= '0;
                r_b_q[k] <= '0;
                r_s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v_q[k] <= w_v_d[k];
                    r_a_q[k] <= w_a_d[k];
                    r_b_q[k] <= w_b_d[k];
                    r_s_q[k] <= w_s_d[k];
                    r_c_q[k] <= w_c_d[k];
                end
            end
            if (w_load[STAGES-1]) begin
                r_ovf_q <= w_ovf_d;
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v_q[STAGES-1];
    assign sum       = r_s_q[STAGES-1];
    assign cout      = r_c_q[STAGES-1];
    assign ovf       = r_ovf_q;

endmodule
`default_nettype wire
